gt_rx_capture: RTL and testbench
================================

# gt_rx_capture

Receive-side counterpart of the GT TX pattern path. Takes per-lane 32-bit user data from the GT receive wrapper and searches each lane independently for a sync word. After sync, it captures a programmable number of words per lane into on-chip RAM, which register logic reads back for loopback and link checking. The block runs entirely in the GT user clock domain; crossing into the AXI-Lite register domain is handled outside this block.

## Interface
Parameters:
- GT_CHN_NUM, 6, number of lanes.
- USER_DATA_WIDTH, 32, bits per lane word.
- RAM_DEPTH, 1024, words per lane buffer; power of two. ADDR_W = log2(RAM_DEPTH).
- SYNC_WORD, 32'hA5A5_5A5A, lane alignment marker.

Ports (one clock; reset is asynchronous and active-high):
- gt_clk  in  1  GT user clock; all logic on rising edge.
- gt_rst  in  1  async active-high reset.
- rx_data  in  GT_CHN_NUM*USER_DATA_WIDTH  lane n at bits [32n+31:32n].
- rx_valid  in  GT_CHN_NUM  per-lane word qualifier.
- reg_start  in  1  level; a rising edge arms a capture.
- reg_reset  in  1  synchronous soft clear, level.
- cap_len  in  ADDR_W+1  words per lane, 1..RAM_DEPTH; 0 means RAM_DEPTH; values above RAM_DEPTH clamp to RAM_DEPTH.
- sync_timeout  in  16  cycles allowed for all lanes to lock; 0 disables the timeout.
- ram_idx  in  3  lane select for readback.
- ram_addr  in  ADDR_W  readback address.
- ram_rdata  out  32  readback data.
- state  out  2  0 IDLE, 1 RUN, 2 DONE, 3 ERR.
- lane_locked  out  GT_CHN_NUM  sync found per lane.
- done_mask  out  GT_CHN_NUM  lane captured cap_len words.
- cap_done  out  1  all lanes complete.
- timeout_err  out  1  sync timeout occurred.

## Operation
- States:
  - IDLE: no capture activity.
  - RUN: sync search and capture.
  - DONE: terminal success.
  - ERR: terminal timeout.
- Starting a capture: a reg_start rising edge (0→1 across consecutive cycles) in IDLE, DONE or ERR enters RUN. On entry it clears lane_locked, done_mask, cap_done, timeout_err, the write pointers and the timeout counter. cap_len is latched at this point. A rising edge while in RUN is ignored.
- reg_reset high: go to IDLE and clear all status outputs. reg_reset takes priority over reg_start and over every RUN event in the same cycle.
- Lane sync (RUN, lane n not yet locked): rx_valid[n] high with word == SYNC_WORD sets lane_locked[n]. The sync word itself is not stored. Words with rx_valid low are never matched or stored.
- Lane capture (RUN, lane n locked and done_mask[n]=0):
  - each rx_valid[n] word is written at address wptr[n], then wptr[n] increments; the first word after sync goes to address 0;
  - a later occurrence of SYNC_WORD is stored as data;
  - when wptr reaches the latched cap_len, done_mask[n] sets and further writes on that lane stop.
- Completion: when done_mask is all ones, move to DONE and set cap_done.
- Timeout: the counter starts at 0 on RUN entry and increments each RUN cycle while not all lanes are locked. With sync_timeout ≠ 0, if the counter equals sync_timeout−1 and some lane is still unlocked after this cycle's matches are taken into account, move to ERR and set timeout_err. A lock in the expiry cycle that completes the lock set wins, and no error is raised. Once all lanes are locked the timeout is inert.
- ERR keeps captured RAM contents and lane_locked as they stand.
- Readback: RAM is GT_CHN_NUM × RAM_DEPTH × 32 and readable in any state. ram_idx ≥ GT_CHN_NUM returns 0. RAM contents are not reset.

## Timing
- Reset values: state=0, lane_locked=0, done_mask=0, cap_done=0, timeout_err=0, ram_rdata=0. Reset mid-RUN aborts immediately; partially written RAM is retained.
- Sync match at cycle t → lane_locked[n] high at t+1. A valid word at t+1 is written to address 0.
- Final write at cycle t → done_mask[n] high at t+1. The last lane's done_mask rising at t+1 → state=DONE and cap_done at t+2.
- Timeout expiry evaluated at cycle t → state=ERR and timeout_err at t+1.
- Readback latency: ram_rdata reflects ram_idx/ram_addr registered one cycle earlier (1-cycle latency). A read and a write to the same address in the same cycle returns the old data.
- Writes on all lanes are independent; simultaneous writes on all lanes every cycle are sustained.

## Test plan
- All 6 lanes: sync at cycle 10, then incrementing words 0..15, cap_len=16 → RAM[n][k]=k, done_mask=6'h3F, cap_done one cycle after the last done_mask bit.
- Lane 2 syncs 40 cycles after the others, sync_timeout=100 → no error; cap_done only after lane 2 completes; lane 0 data unaffected by lane 2 skew.
- Lane 5 never sends SYNC_WORD, sync_timeout=50 → state=3 and timeout_err exactly 50 cycles after RUN entry; cap_done=0.
- SYNC_WORD on rx_data with rx_valid low, rx_valid gaps mid-capture, and SYNC_WORD repeated after lock → no false lock; the post-lock SYNC_WORD is stored; addresses stay contiguous.
- cap_len=0 → 1024 words captured; reg_start held high (no new edge) → no re-arm; reg_reset and reg_start in the same cycle → state=0.
- gt_rst asserted mid-RUN → all outputs 0 asynchronously; restart → clean capture; ram_idx=7 reads 0.

Source files
------------

// File: rtl/gt_rx_capture.sv
// gt_rx_capture: per-lane sync-word search and fixed-length capture into
// per-lane readback RAM, all in the GT user clock domain.
module gt_rx_capture #(
    parameter int GT_CHN_NUM = 6,
    parameter int USER_DATA_WIDTH = 32,
    parameter int RAM_DEPTH = 1024,
    parameter logic [USER_DATA_WIDTH-1:0] SYNC_WORD = 32'hA5A5_5A5A,
    parameter int ADDR_W = $clog2(RAM_DEPTH)
) (
    input  logic                                  gt_clk,
    input  logic                                  gt_rst,
    input  logic [GT_CHN_NUM*USER_DATA_WIDTH-1:0] rx_data,
    input  logic [GT_CHN_NUM-1:0]                 rx_valid,
    input  logic                                  reg_start,
    input  logic                                  reg_reset,
    input  logic [ADDR_W:0]                       cap_len,
    input  logic [15:0]                           sync_timeout,
    input  logic [2:0]                            ram_idx,
    input  logic [ADDR_W-1:0]                     ram_addr,
    output logic [USER_DATA_WIDTH-1:0]            ram_rdata,
    output logic [1:0]                            state,
    output logic [GT_CHN_NUM-1:0]                 lane_locked,
    output logic [GT_CHN_NUM-1:0]                 done_mask,
    output logic                                  cap_done,
    output logic                                  timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_e;

    localparam logic [ADDR_W:0] DEPTH = (ADDR_W + 1)'(RAM_DEPTH);
    localparam logic [ADDR_W:0] ONE_W = (ADDR_W + 1)'(1);

    state_e                  state_q, state_d;
    logic [GT_CHN_NUM-1:0]   locked_q, locked_d;
    logic [GT_CHN_NUM-1:0]   done_q, done_d;
    logic                    cap_done_q, cap_done_d;
    logic                    tmo_q, tmo_d;
    logic [15:0]             cnt_q, cnt_d;
    logic [ADDR_W:0]         len_q, len_d;
    logic [ADDR_W:0]         wptr_q [GT_CHN_NUM];
    logic [ADDR_W:0]         wptr_d [GT_CHN_NUM];
    logic                    start_q;
    logic [2:0]              idx_q;
    logic                    rd_ok_q;
    logic [GT_CHN_NUM-1:0]   we;
    logic                    start_rise;
    logic [ADDR_W:0]         len_clamped;
    logic [GT_CHN_NUM*USER_DATA_WIDTH-1:0] rd_all;

    assign start_rise  = reg_start && !start_q;
    assign len_clamped = (cap_len == '0 || cap_len > DEPTH) ? DEPTH : cap_len;

    always_comb begin
        state_d    = state_q;
        locked_d   = locked_q;
        done_d     = done_q;
        cap_done_d = cap_done_q;
        tmo_d      = tmo_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        wptr_d     = wptr_q;
        we         = '0;
        if (reg_reset) begin
            state_d    = S_IDLE;
            locked_d   = '0;
            done_d     = '0;
            cap_done_d = 1'b0;
            tmo_d      = 1'b0;
            cnt_d      = '0;
            for (int n = 0; n < GT_CHN_NUM; n++) wptr_d[n] = '0;
        end else if (state_q != S_RUN) begin
            if (start_rise) begin
                state_d    = S_RUN;
                locked_d   = '0;
                done_d     = '0;
                cap_done_d = 1'b0;
                tmo_d      = 1'b0;
                cnt_d      = '0;
                len_d      = len_clamped;
                for (int n = 0; n < GT_CHN_NUM; n++) wptr_d[n] = '0;
            end
        end else begin
            for (int n = 0; n < GT_CHN_NUM; n++) begin
                if (rx_valid[n]) begin
                    if (!locked_q[n]) begin
                        if (rx_data[n*USER_DATA_WIDTH +: USER_DATA_WIDTH] == SYNC_WORD)
                            locked_d[n] = 1'b1;
                    end else if (!done_q[n]) begin
                        we[n]     = 1'b1;
                        wptr_d[n] = wptr_q[n] + ONE_W;
                        if (wptr_d[n] == len_q) done_d[n] = 1'b1;
                    end
                end
            end
            // A lock arriving in the expiry cycle that completes the set wins.
            if (&done_q) begin
                state_d    = S_DONE;
                cap_done_d = 1'b1;
            end else if (!(&locked_q)) begin
                cnt_d = cnt_q + 16'd1;
                if (sync_timeout != '0 && cnt_q == sync_timeout - 16'd1
                    && !(&locked_d)) begin
                    state_d = S_ERR;
                    tmo_d   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge gt_clk or posedge gt_rst) begin
        if (gt_rst) begin
            state_q    <= S_IDLE;
            locked_q   <= '0;
            done_q     <= '0;
            cap_done_q <= 1'b0;
            tmo_q      <= 1'b0;
            cnt_q      <= '0;
            len_q      <= DEPTH;
            start_q    <= 1'b0;
            idx_q      <= '0;
            rd_ok_q    <= 1'b0;
            for (int n = 0; n < GT_CHN_NUM; n++) wptr_q[n] <= '0;
        end else begin
            state_q    <= state_d;
            locked_q   <= locked_d;
            done_q     <= done_d;
            cap_done_q <= cap_done_d;
            tmo_q      <= tmo_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            start_q    <= reg_start;
            idx_q      <= ram_idx;
            rd_ok_q    <= 1'b1;
            for (int n = 0; n < GT_CHN_NUM; n++) wptr_q[n] <= wptr_d[n];
        end
    end

    // One RAM per lane so all lanes can write every cycle.
    for (genvar g = 0; g < GT_CHN_NUM; g++) begin : g_lane
        logic [USER_DATA_WIDTH-1:0] mem [RAM_DEPTH];
        logic [USER_DATA_WIDTH-1:0] rd_q;

        always_ff @(posedge gt_clk) begin
            if (we[g])
                mem[wptr_q[g][ADDR_W-1:0]] <=
                    rx_data[g*USER_DATA_WIDTH +: USER_DATA_WIDTH];
            rd_q <= mem[ram_addr];
        end

        assign rd_all[g*USER_DATA_WIDTH +: USER_DATA_WIDTH] = rd_q;
    end

    always_comb begin
        ram_rdata = '0;
        for (int n = 0; n < GT_CHN_NUM; n++) begin
            if (rd_ok_q && 32'(idx_q) == n)
                ram_rdata = rd_all[n*USER_DATA_WIDTH +: USER_DATA_WIDTH];
        end
    end

    assign state       = state_q;
    assign lane_locked = locked_q;
    assign done_mask   = done_q;
    assign cap_done    = cap_done_q;
    assign timeout_err = tmo_q;

endmodule

// File: tb/tb_gt_rx_capture.sv
// tb_gt_rx_capture: randomized lane traffic against a cycle-indexed
// reference model, with a queued scoreboard for status and readback data.
module tb_gt_rx_capture;

    localparam int N  = 6;
    localparam int W  = 32;
    localparam int D  = 1024;
    localparam int AW = 10;
    localparam logic [31:0] SW = 32'hA5A5_5A5A;

    logic           gt_clk = 1'b0;
    logic           gt_rst = 1'b1;
    logic [N*W-1:0] rx_data = '0;
    logic [N-1:0]   rx_valid = '0;
    logic           reg_start = 1'b0;
    logic           reg_reset = 1'b0;
    logic [AW:0]    cap_len = '0;
    logic [15:0]    sync_timeout = '0;
    logic [2:0]     ram_idx = '0;
    logic [AW-1:0]  ram_addr = '0;
    logic [31:0]    ram_rdata;
    logic [1:0]     state;
    logic [N-1:0]   lane_locked;
    logic [N-1:0]   done_mask;
    logic           cap_done;
    logic           timeout_err;

    gt_rx_capture dut (
        .gt_clk(gt_clk),
        .gt_rst(gt_rst),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .reg_start(reg_start),
        .reg_reset(reg_reset),
        .cap_len(cap_len),
        .sync_timeout(sync_timeout),
        .ram_idx(ram_idx),
        .ram_addr(ram_addr),
        .ram_rdata(ram_rdata),
        .state(state),
        .lane_locked(lane_locked),
        .done_mask(done_mask),
        .cap_done(cap_done),
        .timeout_err(timeout_err)
    );

    always #5 gt_clk = ~gt_clk;

    int checks = 0;
    int errors = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Reference model: per-lane word counts and a cycle index inside RUN.
    int          m_state = 0;
    bit [N-1:0]  m_locked = '0;
    bit [N-1:0]  m_done = '0;
    int          m_cnt [N];
    int          m_len = D;
    int          m_tmo = 0;
    int          m_k = 0;
    bit          m_prev = 1'b0;
    logic [31:0] m_ram [N][D];
    bit          m_vld [N][D];

    logic [15:0] exp_st_q [$];
    logic [31:0] exp_rd_q [$];
    bit st_req = 1'b0, rd_req = 1'b0;
    bit st_pend = 1'b0, rd_pend = 1'b0;

    always @(posedge gt_clk) begin
        st_pend <= st_req;
        rd_pend <= rd_req;
    end

    always @(negedge gt_clk) begin
        if (st_pend) begin
            if (exp_st_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL status_queue: empty, required one entry");
            end else begin
                check("status",
                      {48'd0, state, lane_locked, done_mask, cap_done, timeout_err},
                      {48'd0, exp_st_q.pop_front()});
            end
        end
        if (rd_pend) begin
            if (exp_rd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rdata_queue: empty, required one entry");
            end else begin
                check("rdata", {32'd0, ram_rdata}, {32'd0, exp_rd_q.pop_front()});
            end
        end
    end

    task automatic model_step();
        bit rise;
        bit all_done;
        bit [N-1:0] nl;
        rise = reg_start && !m_prev;
        m_prev = reg_start;
        if (reg_reset) begin
            m_state = 0;
            m_locked = '0;
            m_done = '0;
        end else if (m_state != 1) begin
            if (rise) begin
                m_state = 1;
                m_locked = '0;
                m_done = '0;
                foreach (m_cnt[n]) m_cnt[n] = 0;
                m_k = 0;
                m_len = (cap_len == 0 || int'(cap_len) > D) ? D : int'(cap_len);
                m_tmo = int'(sync_timeout);
            end
        end else begin
            all_done = &m_done;
            nl = '0;
            m_k++;
            for (int n = 0; n < N; n++) begin
                if (rx_valid[n]) begin
                    if (!m_locked[n]) begin
                        nl[n] = (rx_data[n*W +: W] == SW);
                    end else if (!m_done[n]) begin
                        m_ram[n][m_cnt[n]] = rx_data[n*W +: W];
                        m_vld[n][m_cnt[n]] = 1'b1;
                        m_cnt[n]++;
                        m_done[n] = (m_cnt[n] == m_len);
                    end
                end
            end
            m_locked |= nl;
            if (all_done) m_state = 2;
            else if (m_tmo != 0 && m_k == m_tmo && !(&m_locked)) m_state = 3;
        end
    endtask

    task automatic tick(bit chk);
        model_step();
        if (chk)
            exp_st_q.push_back({2'(m_state), m_locked, m_done,
                                m_state == 2, m_state == 3});
        st_req = chk;
        @(negedge gt_clk);
    endtask

    int sync_at [N];
    int seq [N];

    task automatic gen_lanes(int c, int gap, int junk, bit incr);
        for (int n = 0; n < N; n++) begin
            logic v;
            logic [31:0] d;
            if (c == sync_at[n]) begin
                v = 1'b1;
                d = SW;
            end else begin
                v = ($urandom_range(99) >= gap);
                d = incr ? 32'(seq[n]) : $urandom;
                if (sync_at[n] < 0 || c < sync_at[n]) begin
                    if (incr) v = 1'b0;
                    if (v && d == SW) d = ~d;
                    if (!v && $urandom_range(99) < junk) d = SW;
                end else begin
                    if (!incr && v && $urandom_range(99) < junk) d = SW;
                    if (incr && v) seq[n]++;
                end
            end
            rx_valid[n] = v;
            rx_data[n*W +: W] = d;
        end
    endtask

    task automatic run_scn(int len, int tmo, int gap, int junk, bit incr,
                           int stop_at, int err_at);
        int c;
        bit seen;
        foreach (seq[n]) seq[n] = 0;
        reg_start = 1'b0;
        tick(1);
        cap_len = (AW + 1)'(len);
        sync_timeout = 16'(tmo);
        reg_start = 1'b1;
        tick(1);
        c = 0;
        seen = 1'b0;
        while (m_state == 1 && c < 3000 && !(stop_at > 0 && c >= stop_at)) begin
            c++;
            gen_lanes(c, gap, junk, incr);
            tick(1);
            if (err_at > 0 && timeout_err && !seen) begin
                seen = 1'b1;
                check("timeout_cycle", 64'(c), 64'(err_at));
            end
        end
        rx_valid = '0;
        if (err_at > 0) check("timeout_seen", {63'd0, seen}, 64'd1);
        if (stop_at == 0) begin
            if (m_state == 1) begin
                checks++;
                errors++;
                $display("FAIL run_bound: still running after %0d cycles", c);
            end
            repeat (3) tick(1);
        end
    endtask

    task automatic rd(int idx, int a, logic [31:0] exp);
        ram_idx = 3'(idx);
        ram_addr = AW'(a);
        exp_rd_q.push_back(exp);
        rd_req = 1'b1;
        tick(1);
        rd_req = 1'b0;
    endtask

    task automatic readback();
        for (int n = 0; n < N; n++)
            for (int a = 0; a < D && m_vld[n][a]; a++)
                rd(n, a, m_ram[n][a]);
        rd(6, int'($urandom_range(D - 1)), 32'd0);
        rd(7, 0, 32'd0);
        rd(7, D - 1, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        foreach (m_cnt[n]) m_cnt[n] = 0;
        repeat (3) @(negedge gt_clk);
        check("rst_state", 64'(state), 64'd0);
        check("rst_locked", 64'(lane_locked), 64'd0);
        check("rst_done", 64'(done_mask), 64'd0);
        check("rst_cap_done", 64'(cap_done), 64'd0);
        check("rst_timeout", 64'(timeout_err), 64'd0);
        check("rst_rdata", 64'(ram_rdata), 64'd0);
        gt_rst = 1'b0;

        foreach (sync_at[n]) sync_at[n] = 10;
        run_scn(16, 0, 0, 0, 1, 0, 0);
        readback();

        foreach (sync_at[n]) sync_at[n] = 10;
        sync_at[2] = 50;
        run_scn(32, 100, 10, 5, 0, 0, 0);
        readback();

        foreach (sync_at[n]) sync_at[n] = 10;
        sync_at[5] = -1;
        run_scn(16, 50, 10, 5, 0, 0, 50);
        check("err_cap_done", 64'(cap_done), 64'd0);
        readback();

        foreach (sync_at[n]) sync_at[n] = int'($urandom_range(20, 1));
        run_scn(64, 200, 30, 20, 0, 0, 0);
        readback();

        foreach (sync_at[n]) sync_at[n] = int'($urandom_range(20, 1));
        run_scn(0, 0, 0, 0, 0, 0, 0);
        readback();

        reg_start = 1'b0;
        tick(1);
        reg_start = 1'b1;
        reg_reset = 1'b1;
        tick(1);
        reg_reset = 1'b0;
        repeat (3) tick(1);
        check("rr_idle", 64'(state), 64'd0);

        foreach (sync_at[n]) sync_at[n] = 5;
        run_scn(600, 0, 0, 0, 0, 200, 0);
        st_req = 1'b0;
        #2 gt_rst = 1'b1;
        #1;
        check("arst_state", 64'(state), 64'd0);
        check("arst_locked", 64'(lane_locked), 64'd0);
        check("arst_done", 64'(done_mask), 64'd0);
        check("arst_cap_done", 64'(cap_done), 64'd0);
        check("arst_timeout", 64'(timeout_err), 64'd0);
        check("arst_rdata", 64'(ram_rdata), 64'd0);
        m_state = 0;
        m_locked = '0;
        m_done = '0;
        m_prev = 1'b0;
        reg_start = 1'b0;
        @(negedge gt_clk);
        @(negedge gt_clk);
        #2 gt_rst = 1'b0;
        @(negedge gt_clk);

        foreach (sync_at[n]) sync_at[n] = 3;
        run_scn(8, 0, 0, 0, 0, 0, 0);
        readback();
        tick(0);
        tick(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
